// File: rtl/avalon_st_sample_fifo.sv
// avalon_st_sample_fifo: first-word fall-through FIFO for an Avalon-ST sample stream.
// Carries SOP/EOP through storage, counts packets out and flags sink-side framing errors.
module avalon_st_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     err_clr,
    input  logic [DATA_W-1:0]        sink_data,
    input  logic                     sink_valid,
    input  logic                     sink_startofpacket,
    input  logic                     sink_endofpacket,
    output logic                     sink_ready,
    output logic [DATA_W-1:0]        source_data,
    output logic                     source_valid,
    output logic                     source_startofpacket,
    output logic                     source_endofpacket,
    input  logic                     source_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              pkt_count,
    output logic                     framing_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, IN_PKT} state_t;
    logic [DATA_W+1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [15:0]       pkt_count_q;
    logic              err_q, err_d, full, empty, wr_acc, rd_acc, frame_bad;
    state_t            state_q, state_d;
    assign empty        = wr_ptr_q == rd_ptr_q;
    assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign sink_ready   = !full;
    assign source_valid = !empty;
    assign level        = wr_ptr_q - rd_ptr_q;
    assign pkt_count    = pkt_count_q;
    assign framing_err  = err_q;
    // Head is masked while empty so stale storage never shows on the source.
    assign {source_startofpacket, source_endofpacket, source_data} = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign wr_acc = sink_valid && !full && !flush;
    assign rd_acc = source_valid && source_ready && !flush;
    always_comb begin
        frame_bad = wr_acc && ((state_q == IN_PKT) == sink_startofpacket);
        state_d   = flush ? IDLE : wr_acc ? (sink_endofpacket ? IDLE : IN_PKT) : state_q;
        err_d     = frame_bad || (err_q && !err_clr);
    end
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= {sink_startofpacket, sink_endofpacket, sink_data};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= IDLE;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= flush ? '0 : wr_ptr_q + (AW+1)'(wr_acc);
            rd_ptr_q    <= flush ? '0 : rd_ptr_q + (AW+1)'(rd_acc);
            state_q     <= state_d;
            pkt_count_q <= pkt_count_q + 16'(rd_acc && source_endofpacket);
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_avalon_st_sample_fifo.sv
// tb_avalon_st_sample_fifo: directed vector table plus queue-model sequences for the sample FIFO.
module tb_avalon_st_sample_fifo;
    localparam int DEPTH = 16;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, err_clr = 1'b0;
    logic [15:0] sink_data = '0, source_data, pkt_count;
    logic        sink_valid = 1'b0, sink_startofpacket = 1'b0, sink_endofpacket = 1'b0, sink_ready;
    logic        source_valid, source_startofpacket, source_endofpacket, source_ready = 1'b0;
    logic [4:0]  level;
    logic        framing_err;
    int          n_chk = 0, n_pass = 0;
    logic [17:0] q[$];
    logic        mst = 1'b0, mfe = 1'b0, dmy;
    logic [15:0] mpc = '0;

    avalon_st_sample_fifo #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr),
        .sink_data(sink_data), .sink_valid(sink_valid),
        .sink_startofpacket(sink_startofpacket), .sink_endofpacket(sink_endofpacket),
        .sink_ready(sink_ready), .source_data(source_data), .source_valid(source_valid),
        .source_startofpacket(source_startofpacket), .source_endofpacket(source_endofpacket),
        .source_ready(source_ready), .level(level), .pkt_count(pkt_count), .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    // ctl = {flush, err_clr, valid, sop, eop, source_ready}; ef = {sink_ready, source_valid, sop, eop, framing_err}
    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] d;
        logic [4:0]  ef;
        logic [15:0] sd;
        logic [4:0]  lvl;
        logic [15:0] pc;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        n_chk++;
        if (a === x) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, a, x);
    endtask

    task automatic model_cmp(input string nm);
        chk({nm, ".level"}, 32'(level), 32'(q.size()));
        chk({nm, ".sink_ready"}, 32'(sink_ready), 32'(q.size() < DEPTH));
        chk({nm, ".source_valid"}, 32'(source_valid), 32'(q.size() > 0));
        chk({nm, ".pkt_count"}, 32'(pkt_count), 32'(mpc));
        chk({nm, ".framing_err"}, 32'(framing_err), 32'(mfe));
        if (q.size() > 0)
            chk({nm, ".head"}, 32'({source_startofpacket, source_endofpacket, source_data}), 32'(q[0]));
    endtask

    task automatic cyc(input string nm, input logic [5:0] ctl, input logic [15:0] d, output logic acc);
        logic wr, rd, err;
        {flush, err_clr, sink_valid, sink_startofpacket, sink_endofpacket, source_ready} = ctl;
        sink_data = d;
        wr = ctl[3] && q.size() < DEPTH && !ctl[5];
        rd = ctl[0] && q.size() > 0 && !ctl[5];
        @(posedge clk);
        err = 1'b0;
        if (ctl[5]) begin
            q.delete();
            mst = 1'b0;
        end else begin
            if (rd) begin
                if (q[0][16]) mpc++;
                void'(q.pop_front());
            end
            if (wr) begin
                err = mst ? ctl[2] : !ctl[2];
                mst = !ctl[1];
                q.push_back({ctl[2], ctl[1], d});
            end
        end
        mfe = err || (mfe && !ctl[4]);
        acc = wr;
        #1;
        model_cmp(nm);
    endtask

    task automatic do_reset();
        {flush, err_clr, sink_valid, sink_startofpacket, sink_endofpacket, source_ready} = 6'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mst = 1'b0;
        mfe = 1'b0;
        mpc = '0;
        chk("rst.sink_ready", 32'(sink_ready), 32'd1);
        chk("rst.source_valid", 32'(source_valid), 32'd0);
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.pkt_count", 32'(pkt_count), 32'd0);
        chk("rst.framing_err", 32'(framing_err), 32'd0);
        chk("rst.source_bus", 32'({source_startofpacket, source_endofpacket, source_data}), 32'd0);
    endtask

    initial begin
        int idx, sent, npk, pos, plen;
        logic v, r, s, e, a;
        logic [15:0] dat;
        vt[0]  = '{6'b001100, 16'h000A, 5'b11100, 16'h000A, 5'd1, 16'd0};
        vt[1]  = '{6'b001010, 16'h000B, 5'b11100, 16'h000A, 5'd2, 16'd0};
        vt[2]  = '{6'b000001, 16'h0000, 5'b11010, 16'h000B, 5'd1, 16'd0};
        vt[3]  = '{6'b000001, 16'h0000, 5'b10000, 16'h0000, 5'd0, 16'd1};
        vt[4]  = '{6'b001001, 16'h0011, 5'b11001, 16'h0011, 5'd1, 16'd1};
        vt[5]  = '{6'b010000, 16'h0000, 5'b11000, 16'h0011, 5'd1, 16'd1};
        vt[6]  = '{6'b011101, 16'h0012, 5'b11101, 16'h0012, 5'd1, 16'd1};
        vt[7]  = '{6'b011011, 16'h0013, 5'b11010, 16'h0013, 5'd1, 16'd1};
        vt[8]  = '{6'b101111, 16'h0014, 5'b10000, 16'h0000, 5'd0, 16'd1};
        vt[9]  = '{6'b001110, 16'h0015, 5'b11110, 16'h0015, 5'd1, 16'd1};
        vt[10] = '{6'b000001, 16'h0000, 5'b10000, 16'h0000, 5'd0, 16'd2};
        vt[11] = '{6'b001100, 16'h0016, 5'b11100, 16'h0016, 5'd1, 16'd2};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            {flush, err_clr, sink_valid, sink_startofpacket, sink_endofpacket, source_ready} = vt[i].ctl;
            sink_data = vt[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.flags", i),
                32'({sink_ready, source_valid, source_startofpacket, source_endofpacket, framing_err}), 32'(vt[i].ef));
            chk($sformatf("vec%0d.data", i), 32'(source_data), 32'(vt[i].sd));
            chk($sformatf("vec%0d.level", i), 32'(level), 32'(vt[i].lvl));
            chk($sformatf("vec%0d.pkt_count", i), 32'(pkt_count), 32'(vt[i].pc));
        end

        // Streaming: each beat appears right after its write, one packet of 8.
        do_reset();
        for (int i = 0; i < 8; i++)
            cyc("stream", {3'b001, i == 0, i == 7, 1'b1}, 16'(i + 1), dmy);
        cyc("stream_tail", 6'b000001, 16'h0, dmy);
        chk("stream.pkt_count", 32'(pkt_count), 32'd1);
        chk("stream.level", 32'(level), 32'd0);

        // Flush with a concurrent write and read.
        for (int i = 0; i < 4; i++)
            cyc("pre_flush", {3'b001, i == 0, 1'b0, 1'b0}, 16'h40 + 16'(i), dmy);
        cyc("flush", 6'b101001, 16'h0099, dmy);
        chk("flush.level", 32'(level), 32'd0);
        chk("flush.source_valid", 32'(source_valid), 32'd0);
        chk("flush.pkt_count", 32'(pkt_count), 32'd1);
        cyc("post_flush", 6'b000001, 16'h0, dmy);

        // Fill to DEPTH with the sink stalled, then drain all 20 beats.
        do_reset();
        idx = 0;
        for (int c = 0; c < 24; c++) begin
            cyc("fill", {3'b001, idx == 0, idx == 19, 1'b0}, 16'h100 + 16'(idx), a);
            if (a) idx++;
        end
        chk("fill.level", 32'(level), 32'd16);
        chk("fill.sink_ready", 32'(sink_ready), 32'd0);
        chk("fill.accepted", 32'(idx), 32'd16);
        for (int c = 0; c < 100 && (idx < 20 || q.size() > 0); c++) begin
            cyc("drain", {2'b00, idx < 20, idx == 0, idx == 19, 1'b1}, 16'h100 + 16'(idx), a);
            if (a) idx++;
        end
        chk("drain.accepted", 32'(idx), 32'd20);
        chk("drain.level", 32'(level), 32'd0);
        chk("drain.pkt_count", 32'(pkt_count), 32'd1);

        // Reset in the middle of a burst drops everything.
        for (int i = 0; i < 3; i++)
            cyc("pre_rst", {3'b001, i == 0, 1'b0, 1'b0}, 16'h200 + 16'(i), dmy);
        do_reset();

        // pkt_count wraps after 65536 single-beat packets.
        for (int i = 0; i < 65536; i++)
            cyc("wrap", 6'b001111, 16'(i), dmy);
        chk("wrap.pkt_ffff", 32'(pkt_count), 32'hFFFF);
        cyc("wrap_tail", 6'b000001, 16'h0, dmy);
        chk("wrap.pkt_zero", 32'(pkt_count), 32'd0);
        chk("wrap.framing_err", 32'(framing_err), 32'd0);

        // Random valid/ready with well-formed packets of 1..40 beats.
        do_reset();
        sent = 0;
        npk = 0;
        pos = 0;
        plen = $urandom_range(1, 40);
        dat = 16'($urandom);
        for (int c = 0; c < 20000 && sent < 2000; c++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            s = pos == 0;
            e = pos == plen - 1;
            cyc("rand", {2'b00, v, s, e, r}, dat, a);
            if (a) begin
                sent++;
                dat = 16'($urandom);
                if (e) begin
                    npk++;
                    pos = 0;
                    plen = $urandom_range(1, 40);
                end else pos++;
            end
        end
        for (int c = 0; c < 200 && q.size() > 0; c++)
            cyc("rand_drain", 6'b000001, 16'h0, dmy);
        chk("rand.sent", 32'(sent), 32'd2000);
        chk("rand.level", 32'(level), 32'd0);
        chk("rand.pkt_count", 32'(pkt_count), 32'(16'(npk)));
        chk("rand.framing_err", 32'(framing_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
